// File: rtl/oam_dma_bus_unit.sv
// ============================================================================
// Module   : oam_dma_bus_unit
// Brief    : CPU-to-system-bus stage with NES sprite DMA ($4014 -> $2004).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module oam_dma_bus_unit #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  bus_din,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic        cpu_pause,
  output logic        dma_done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DUMMY = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  state_t      r_state;
  logic        r_odd;
  logic [7:0]  r_idx;
  logic [7:0]  r_page;
  logic [7:0]  r_latch;
  logic        w_trigger;

  assign w_trigger = cpu_wr && (cpu_addr == DMA_REG_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_odd   <= 1'b0;
      r_idx   <= 8'h00;
      r_page  <= 8'h00;
      r_latch <= 8'h00;
    end else if (ce) begin
      r_odd <= ~r_odd;
      case (r_state)
        ST_IDLE: begin
          if (w_trigger) begin
            r_page  <= cpu_dout;
            r_idx   <= 8'h00;
            r_state <= ST_DUMMY;
          end
        end
        // Reads must land on the even (get) phase, so an odd dummy cycle skips ALIGN.
        ST_DUMMY: r_state <= r_odd ? ST_READ : ST_ALIGN;
        ST_ALIGN: r_state <= ST_READ;
        ST_READ: begin
          r_latch <= bus_din;
          r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          if (r_idx == 8'hFF) begin
            r_state <= ST_IDLE;
          end else begin
            r_idx   <= r_idx + 8'h01;
            r_state <= ST_READ;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus_addr = cpu_addr;
    bus_dout = cpu_dout;
    bus_rd   = 1'b0;
    bus_wr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus_rd = cpu_rd;
        bus_wr = cpu_wr;
      end
      ST_READ: begin
        bus_addr = {r_page, r_idx};
        bus_rd   = 1'b1;
      end
      ST_WRITE: begin
        bus_addr = OAM_DATA_ADDR;
        bus_dout = r_latch;
        bus_wr   = 1'b1;
      end
      default: ;
    endcase
  end

  assign cpu_pause = (r_state != ST_IDLE);
  assign dma_done  = (r_state == ST_WRITE) && (r_idx == 8'hFF);

endmodule

`default_nettype wire

// File: tb/tb_oam_dma_bus_unit.sv
// ============================================================================
// Module   : tb_oam_dma_bus_unit
// Brief    : Randomized bench for oam_dma_bus_unit against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_oam_dma_bus_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_dout = 8'h00;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  bus_din;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_rd;
  logic        bus_wr;
  logic        cpu_pause;
  logic        dma_done;

  oam_dma_bus_unit dut (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .cpu_addr (cpu_addr),
    .cpu_dout (cpu_dout),
    .cpu_rd   (cpu_rd),
    .cpu_wr   (cpu_wr),
    .bus_din  (bus_din),
    .bus_addr (bus_addr),
    .bus_dout (bus_dout),
    .bus_rd   (bus_rd),
    .bus_wr   (bus_wr),
    .cpu_pause(cpu_pause),
    .dma_done (dma_done)
  );

  always #5 clk = ~clk;

  // Memory contents: page 02 holds i ^ 5A.
  function automatic logic [7:0] memByte(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'h02;
  endfunction

  assign bus_din = memByte(bus_addr);

  // Expected bus cycle per ce cycle while a DMA is in flight.
  localparam logic [1:0] K_STALL = 2'd0;
  localparam logic [1:0] K_READ  = 2'd1;
  localparam logic [1:0] K_WRITE = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        done;
  } acc_t;

  acc_t q[$];
  bit   mOdd = 1'b0;
  int   nChecks = 0;
  int   nErrors = 0;
  int   pauseCnt, doneCnt, zeroReads, oamWrites;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkPassThrough(input string tag);
    checkEq({tag, "_addr"}, bus_addr, cpu_addr);
    checkEq({tag, "_dout"}, bus_dout, cpu_dout);
    checkEq({tag, "_rd"}, bus_rd, cpu_rd);
    checkEq({tag, "_wr"}, bus_wr, cpu_wr);
    checkEq({tag, "_pause"}, cpu_pause, 1'b0);
    checkEq({tag, "_done"}, dma_done, 1'b0);
  endtask

  // One CPU cycle: drive, compare mid-cycle, then advance the model on ce.
  task automatic step(input bit ceV, input logic [15:0] a, input logic [7:0] d,
                      input bit rd, input bit wr);
    acc_t e;
    ce = ceV; cpu_addr = a; cpu_dout = d; cpu_rd = rd; cpu_wr = wr;
    @(negedge clk);
    if (q.size() == 0) begin
      checkPassThrough("idle");
    end else begin
      e = q[0];
      checkEq("pause", cpu_pause, 1'b1);
      checkEq("done", dma_done, e.done);
      case (e.kind)
        K_STALL: begin
          checkEq("stall_addr", bus_addr, a);
          checkEq("stall_rd", bus_rd, 1'b0);
          checkEq("stall_wr", bus_wr, 1'b0);
        end
        K_READ: begin
          checkEq("read_addr", bus_addr, e.addr);
          checkEq("read_rd", bus_rd, 1'b1);
          checkEq("read_wr", bus_wr, 1'b0);
        end
        default: begin
          checkEq("write_addr", bus_addr, 16'h2004);
          checkEq("write_data", bus_dout, e.data);
          checkEq("write_rd", bus_rd, 1'b0);
          checkEq("write_wr", bus_wr, 1'b1);
        end
      endcase
    end
    if (ceV) begin
      if (cpu_pause) pauseCnt++;
      if (dma_done) doneCnt++;
      if (cpu_pause && bus_rd && bus_addr == 16'h0000) zeroReads++;
      if (bus_wr && bus_addr == 16'h2004) oamWrites++;
      if (q.size() != 0) begin
        void'(q.pop_front());
      end else if (wr && a == 16'h4014) begin
        q.push_back('{K_STALL, 16'h0000, 8'h00, 1'b0});
        if (mOdd) q.push_back('{K_STALL, 16'h0000, 8'h00, 1'b0});
        for (int i = 0; i < 256; i++) begin
          q.push_back('{K_READ, {d, 8'(i)}, 8'h00, 1'b0});
          q.push_back('{K_WRITE, 16'h2004, memByte({d, 8'(i)}), (i == 255)});
        end
      end
      mOdd = ~mOdd;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleStep(input bit ceV);
    logic [15:0] a;
    a = 16'($urandom);
    if (a == 16'h4014) a = 16'h4015;
    step(ceV, a, 8'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic busyStep(input bit ceV);
    if ($urandom_range(0, 15) == 0)
      step(ceV, 16'h4014, 8'($urandom), 1'b0, 1'b1);
    else
      step(ceV, 16'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic runDma(input logic [7:0] page, input bit parity, input bit ceRand);
    int guard;
    while (mOdd != parity) idleStep(1'b1);
    pauseCnt = 0; doneCnt = 0; zeroReads = 0;
    step(1'b1, 16'h4014, page, 1'b0, 1'b1);
    guard = 0;
    while (q.size() != 0 && guard < 4000) begin
      busyStep(ceRand ? ($urandom_range(0, 2) != 0) : 1'b1);
      guard++;
    end
    checkEq("dma_finished", q.size(), 0);
    q.delete();
    checkEq("pause_len", pauseCnt, parity ? 514 : 513);
    checkEq("done_count", doneCnt, 1);
    checkEq("read_0000", zeroReads, 0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    #2;
    checkPassThrough("rst_async");
    q.delete();
    mOdd = 1'b0;
    @(posedge clk);
    #1;
    checkPassThrough("rst_hold");
    reset = 1'b0;
  endtask

  initial begin
    #2;
    checkPassThrough("rst_init");
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) idleStep(1'($urandom));

    runDma(8'h02, 1'b0, 1'b0);
    repeat (3) idleStep(1'b1);
    runDma(8'h02, 1'b1, 1'b0);
    repeat (3) idleStep(1'b1);
    runDma(8'($urandom), 1'($urandom), 1'b1);
    runDma(8'hFF, 1'b0, 1'b1);
    runDma(8'hFF, 1'b1, 1'b0);

    pauseCnt = 0;
    step(1'b1, 16'h4015, 8'h02, 1'b0, 1'b1);
    step(1'b1, 16'h4014, 8'h02, 1'b1, 1'b0);
    step(1'b0, 16'h4014, 8'h02, 1'b0, 1'b1);
    step(1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
    checkEq("no_trigger_pause", pauseCnt, 0);

    while (mOdd) idleStep(1'b1);
    step(1'b1, 16'h4014, 8'h02, 1'b0, 1'b1);
    repeat (100) busyStep(1'b1);
    doReset();
    oamWrites = 0;
    pauseCnt = 0;
    repeat (20) step(1'b1, 16'($urandom_range(0, 16'h1FFF)), 8'($urandom), 1'($urandom), 1'b0);
    checkEq("post_reset_oam_wr", oamWrites, 0);
    checkEq("post_reset_pause", pauseCnt, 0);
    runDma(8'h02, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/oam_dma_bus_unit.md
Name: oam_dma_bus_unit

Overview:
- Sits directly downstream of the CPU address generator/PC mux. Consumes the CPU's 16-bit address, data-out and read/write strobes, and drives the system bus.
- Implements NES sprite DMA: a CPU write to DMA_REG_ADDR stalls the CPU and copies 256 bytes from page {data,8'h00} to the OAM data port.
- When idle, it is a transparent pass-through of CPU bus cycles.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers DMA.
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ce  in  1  CPU-cycle enable; all state advances only when ce=1
- cpu_addr  in  16  CPU address (AX/PC after CPU mux)
- cpu_dout  in  8  CPU write data
- cpu_rd  in  1  CPU read strobe
- cpu_wr  in  1  CPU write strobe
- bus_din  in  8  data returned by the system bus in the current cycle
- bus_addr  out  16  system bus address
- bus_dout  out  8  system bus write data
- bus_rd  out  1  bus read strobe
- bus_wr  out  1  bus write strobe
- cpu_pause  out  1  stall request to the CPU
- dma_done  out  1  one-ce-cycle pulse on the final DMA write

Behaviour:
- Reset (async, high):
  - state=IDLE, odd=0, idx=0, page=0, latch=0, dma_done=0.
  - Outputs are then in pass-through with cpu_pause=0.
- odd flop: toggles on every ce cycle, including while idle. It is the CPU get/put phase reference.
- States: IDLE, DUMMY, ALIGN, READ, WRITE. The state register updates only when ce=1. With ce=0, all registers hold and outputs stay stable.
- IDLE:
  - Outputs: bus_addr=cpu_addr, bus_dout=cpu_dout, bus_rd=cpu_rd, bus_wr=cpu_wr, cpu_pause=0.
  - Trigger condition: cpu_wr=1 and cpu_addr==DMA_REG_ADDR in a ce cycle.
  - On trigger: page<=cpu_dout, idx<=0, next=DUMMY. The triggering write itself still passes to the bus.
- cpu_pause is combinational: 1 whenever state!=IDLE.
- DUMMY (1 cycle):
  - Outputs: bus_rd=0, bus_wr=0, bus_addr=cpu_addr.
  - next = READ if odd==1, else ALIGN.
- ALIGN (1 cycle): no bus access; next=READ. As a result READ is always entered with odd==0.
- READ:
  - Outputs: bus_addr={page,idx}, bus_rd=1, bus_wr=0.
  - On ce: latch<=bus_din, next=WRITE.
- WRITE:
  - Outputs: bus_addr=OAM_DATA_ADDR, bus_dout=latch, bus_wr=1, bus_rd=0.
  - On ce, if idx==8'hFF: dma_done=1 for this cycle, next=IDLE.
  - Otherwise: idx<=idx+1, next=READ.
- dma_done is combinational: (state==WRITE && idx==8'hFF). It is 1 for exactly one ce cycle per DMA.
- Total pause length:
  - 513 ce cycles if the trigger cycle had odd==0.
  - 514 ce cycles if the trigger cycle had odd==1.
- Width rules: idx is 8 bits. The source address is {page,idx}, so page FF covers 16'hFF00..16'hFFFF; there is no carry into page and no wrap into page 00.
- CPU strobes are ignored in every state except IDLE; a $4014 write cannot retrigger mid-DMA.
- Reset mid-DMA: return immediately to IDLE. cpu_pause drops asynchronously and no further DMA accesses occur.

Test Plan:
- Reset: assert reset mid-run -> cpu_pause=0, bus_* mirror cpu_* combinationally, dma_done=0.
- Even-phase trigger:
  - Stimulus: write 8'h02 to 16'h4014 on an odd==0 cycle, memory[0x0200+i]=i^8'h5A.
  - Response: cpu_pause high for exactly 513 ce cycles. First READ addr 16'h0200 one cycle after DUMMY. 256 writes to 16'h2004 with data i^8'h5A in order. dma_done pulses once, coincident with the write of 8'hA5 (idx FF).
- Odd-phase trigger: same as the even-phase test, but triggered on an odd==1 cycle -> 514 pause cycles, one ALIGN cycle with no bus strobes, and the first READ with odd==0.
- ce gating: toggle ce 1/0 pseudo-randomly during DMA -> identical bus access sequence per ce cycle, and outputs frozen while ce=0.
- Page boundary: trigger with page 8'hFF -> reads span 16'hFF00..16'hFFFF, never 16'h0000, and the last write sources the byte at 16'hFFFF.
- Non-trigger and reset cases:
  - cpu_wr to 16'h4015 or cpu_rd of 16'h4014 -> no pause.
  - Reset asserted after 100 DMA cycles -> immediate IDLE with no further 16'h2004 writes.
  - A subsequent $4014 write after reset restarts DMA at idx 0.
